// File: rtl/instr_fetch_pkg.sv
// Shared opcode encodings and IF-stage FSM state type for the 16-bit pipelined CPU.
package instr_fetch_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LOAD = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_e;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: carries instruction, PC+1 and valid; priority reset > flush > load > hold.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] ir_d,
  input  logic [ADDR_W-1:0] pc_d,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  localparam logic [DATA_W-1:0] NOP_WORD = {OP_NOP, {(DATA_W-OPCODE_W){1'b0}}};

  logic [DATA_W-1:0] ir_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              vld_p1;

  // IF -> ID boundary; a flush keeps pc_p1 since a bubble's PC is never consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_p1  <= NOP_WORD;
      pc_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      ir_p1  <= NOP_WORD;
      vld_p1 <= 1'b0;
    end else if (load) begin
      ir_p1  <= ir_d;
      pc_p1  <= pc_d;
      vld_p1 <= 1'b1;
    end
  end

  assign ir    = ir_p1;
  assign pc    = pc_p1;
  assign valid = vld_p1;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM, handles stall/branch/HALT.
// Optional performance counters are enabled with `define IFETCH_PERF_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] id_ir,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_bubble_cnt
`endif
);

  if_state_e         state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_plus1;
  logic              load, flush;

  assign pc_plus1 = pc + ADDR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        flush = 1'b1;
        if (start) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_n  = branch_target;
          flush = 1'b1;
        end else if (!stall) begin
          load = 1'b1;
          // HALT is delivered once and PC parks on it until a redirect arrives
          if (imem_rdata[DATA_W-1 -: OPCODE_W] == OP_HALT) state_n = ST_HALTED;
          else                                             pc_n    = pc_plus1;
        end
      end
      ST_HALTED: begin
        flush = 1'b1;
        if (branch_taken) begin
          pc_n    = branch_target;
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_IDLE;
        flush   = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .load  (load),
    .ir_d  (imem_rdata),
    .pc_d  (pc_plus1),
    .ir    (id_ir),
    .pc    (id_pc),
    .valid (id_valid)
  );

  assign imem_addr = pc;
  assign halted    = (state == ST_HALTED);

`ifdef IFETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (load) perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
      if (state == ST_RUN && (stall || branch_taken)) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch against a behavioural instruction ROM.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset, start, stall, branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] id_ir;
  logic [7:0]  id_pc;
  logic        id_valid, halted;
  logic [15:0] rom [256];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign imem_rdata = rom[imem_addr];

  instr_fetch #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'd0)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_ir         (id_ir),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .halted        (halted)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;
    step(); step();
    total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", imem_addr); end
    total++; if (id_ir !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h want=0000", id_ir); end
    total++; if (id_pc !== 8'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", id_pc); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", id_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    reset = 1'b0;
    step();
    total++; if (imem_addr !== 8'd0 || id_valid !== 1'b0) begin bad++; $display("FAIL idle_hold got addr=%0d vld=%b want addr=0 vld=0", imem_addr, id_valid); end
  endtask

  task automatic test_fetch();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (imem_addr !== 8'd0 || id_valid !== 1'b0) begin bad++; $display("FAIL enter_run got addr=%0d vld=%b want addr=0 vld=0", imem_addr, id_valid); end
    step();
    total++; if (id_ir !== 16'h0800 || id_pc !== 8'd1 || id_valid !== 1'b1) begin bad++; $display("FAIL fetch0 got ir=%h pc=%0d vld=%b want ir=0800 pc=1 vld=1", id_ir, id_pc, id_valid); end
    step();
    total++; if (id_ir !== 16'h0801 || id_pc !== 8'd2) begin bad++; $display("FAIL fetch1 got ir=%h pc=%0d want ir=0801 pc=2", id_ir, id_pc); end
    step();
    total++; if (id_ir !== 16'h1002 || id_pc !== 8'd3 || imem_addr !== 8'd3) begin bad++; $display("FAIL fetch2 got ir=%h pc=%0d addr=%0d want ir=1002 pc=3 addr=3", id_ir, id_pc, imem_addr); end
  endtask

  task automatic test_stall();
    step(); step();
    total++; if (imem_addr !== 8'd5 || id_ir !== 16'h0804) begin bad++; $display("FAIL pre_stall got addr=%0d ir=%h want addr=5 ir=0804", imem_addr, id_ir); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_addr !== 8'd5 || id_ir !== 16'h0804 || id_pc !== 8'd5 || id_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got addr=%0d ir=%h pc=%0d vld=%b want addr=5 ir=0804 pc=5 vld=1", i, imem_addr, id_ir, id_pc, id_valid); end
    end
    stall = 1'b0;
    step();
    total++; if (id_ir !== 16'h0805 || id_pc !== 8'd6 || imem_addr !== 8'd6) begin bad++; $display("FAIL stall_release got ir=%h pc=%0d addr=%0d want ir=0805 pc=6 addr=6", id_ir, id_pc, imem_addr); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 8'd9;
    step();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 8'd9 || id_ir !== 16'h0000 || id_valid !== 1'b0) begin bad++; $display("FAIL branch_flush got addr=%0d ir=%h vld=%b want addr=9 ir=0000 vld=0", imem_addr, id_ir, id_valid); end
    step();
    total++; if (id_ir !== 16'h0809 || id_pc !== 8'd10 || id_valid !== 1'b1) begin bad++; $display("FAIL branch_fetch got ir=%h pc=%0d vld=%b want ir=0809 pc=10 vld=1", id_ir, id_pc, id_valid); end
  endtask

  task automatic test_branch_over_stall();
    branch_taken = 1'b1; stall = 1'b1; branch_target = 8'd20;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    total++; if (imem_addr !== 8'd20 || id_ir !== 16'h0000 || id_valid !== 1'b0) begin bad++; $display("FAIL branch_stall got addr=%0d ir=%h vld=%b want addr=20 ir=0000 vld=0", imem_addr, id_ir, id_valid); end
    step(); step(); step();
    total++; if (imem_addr !== 8'd23 || id_ir !== 16'h0816) begin bad++; $display("FAIL pre_halt got addr=%0d ir=%h want addr=23 ir=0816", imem_addr, id_ir); end
  endtask

  task automatic test_halt();
    step();
    total++; if (id_ir !== 16'hF800 || id_valid !== 1'b1 || halted !== 1'b1 || imem_addr !== 8'd23) begin bad++; $display("FAIL halt_once got ir=%h vld=%b halted=%b addr=%0d want ir=f800 vld=1 halted=1 addr=23", id_ir, id_valid, halted, imem_addr); end
    stall = 1'b1;
    step();
    stall = 1'b0;
    total++; if (id_ir !== 16'h0000 || id_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'd23) begin bad++; $display("FAIL halt_parked got ir=%h vld=%b halted=%b addr=%0d want ir=0000 vld=0 halted=1 addr=23", id_ir, id_valid, halted, imem_addr); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (halted !== 1'b1 || imem_addr !== 8'd23) begin bad++; $display("FAIL halt_start_ignored got halted=%b addr=%0d want halted=1 addr=23", halted, imem_addr); end
    branch_taken = 1'b1; branch_target = 8'd12;
    step();
    branch_taken = 1'b0;
    total++; if (halted !== 1'b0 || imem_addr !== 8'd12 || id_valid !== 1'b0) begin bad++; $display("FAIL halt_resume got halted=%b addr=%0d vld=%b want halted=0 addr=12 vld=0", halted, imem_addr, id_valid); end
    step();
    total++; if (id_ir !== 16'h080C || id_pc !== 8'd13 || id_valid !== 1'b1) begin bad++; $display("FAIL resume_fetch got ir=%h pc=%0d vld=%b want ir=080c pc=13 vld=1", id_ir, id_pc, id_valid); end
  endtask

  task automatic test_halt_discard();
    branch_taken = 1'b1; branch_target = 8'd23;
    step();
    branch_target = 8'd30;
    step();
    branch_taken = 1'b0;
    total++; if (halted !== 1'b0 || imem_addr !== 8'd30 || id_valid !== 1'b0) begin bad++; $display("FAIL halt_discard got halted=%b addr=%0d vld=%b want halted=0 addr=30 vld=0", halted, imem_addr, id_valid); end
  endtask

  task automatic test_wrap_and_reset();
    branch_taken = 1'b1; branch_target = 8'd255;
    step();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 8'd255) begin bad++; $display("FAIL wrap_pre got addr=%0d want 255", imem_addr); end
    step();
    total++; if (imem_addr !== 8'd0 || id_ir !== 16'h08FF || id_pc !== 8'd0) begin bad++; $display("FAIL wrap got addr=%0d ir=%h pc=%0d want addr=0 ir=08ff pc=0", imem_addr, id_ir, id_pc); end
    step();
    total++; if (imem_addr !== 8'd1 || id_ir !== 16'h0800) begin bad++; $display("FAIL wrap_next got addr=%0d ir=%h want addr=1 ir=0800", imem_addr, id_ir); end
    reset = 1'b1; branch_taken = 1'b1; branch_target = 8'd40; start = 1'b1;
    step();
    reset = 1'b0; branch_taken = 1'b0; start = 1'b0;
    total++; if (imem_addr !== 8'd0 || id_ir !== 16'h0000 || id_pc !== 8'd0 || id_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL mid_reset got addr=%0d ir=%h pc=%0d vld=%b halted=%b want all zero", imem_addr, id_ir, id_pc, id_valid, halted); end
    step(); step();
    total++; if (imem_addr !== 8'd0 || id_valid !== 1'b0) begin bad++; $display("FAIL reset_idle got addr=%0d vld=%b want addr=0 vld=0", imem_addr, id_valid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0800 + 16'(i);
    rom[2]  = 16'h1002;
    rom[23] = 16'hF800;
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_halt();
    test_halt_discard();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
